enigma_stream_ctrl: RTL
=======================

// Module: enigma_stream_ctrl
// PURPOSE
//  Sequencer in front of the enigma pipeline (3 rotors, reflector, 3 return rotors). Runs the
//  configuration phase (set pulse + settle), then streams message bytes into the pipeline
//  over a valid/ready slave port.
//  The pipeline has no backpressure, so results go into an output FIFO, and credit-based
//  admission guarantees that FIFO never overflows. Tags the last result byte and flags message completion.
// PARAMETERS
//  FIFO_DEPTH   8   result FIFO entries, also max in-flight + buffered bytes (power of 2, >=2)
//  SETTLE_CYC   2   idle cycles after eng_set deasserts before the first byte is admitted (>=1)
//  CNT_W        16  width of sent/received byte counters (max message = 2^CNT_W-1 bytes)
// PORTS
//  clk        in   1   clock, all logic rising-edge
//  reset      in   1   asynchronous, active-high; clears all state
//  cfg_start  in   1   1-cycle request: configure engine, then open a message
//  cfg_dec    in   1   decrypt select, sampled with cfg_start, held for the session
//  s_valid    in   1   input byte valid
//  s_data     in   8   input byte
//  s_last     in   1   marks final byte of message
//  s_ready    out  1   byte accepted when s_valid & s_ready
//  m_valid    out  1   result byte valid (FIFO not empty)
//  m_data     out  8   result byte
//  m_last     out  1   result is last byte of message
//  m_ready    in   1   result consumed when m_valid & m_ready
//  eng_set    out  1   to engine set (latches offsets/wiring)
//  eng_en     out  1   to engine en
//  eng_valid  out  1   to engine valid, 1 cycle per byte
//  eng_din    out  8   to engine din
//  eng_dec    out  1   to engine dec
//  eng_done   in   1   from engine done
//  eng_dout   in   8   from engine dout
//  busy       out  1   state != IDLE
//  msg_done   out  1   1-cycle pulse when last result is popped
//  err_ovf    out  1   sticky: eng_done while FIFO full, or eng_done with in-flight==0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters, FIFO pointers and err_ovf cleared.
//  FSM: IDLE -cfg_start-> SET (eng_set=1 for exactly 1 cycle) -> SETTLE (SETTLE_CYC cycles)
//   -> RUN -accepted s_last-> DRAIN -last result popped-> IDLE (msg_done pulse same cycle).
//  cfg_start outside IDLE is ignored. The eng_dec register is loaded from cfg_dec in IDLE on cfg_start.
//  eng_en=1 in RUN and DRAIN, else 0.
//  s_ready = (state==RUN) & (in_flight + fifo_count < FIFO_DEPTH); 0 in all other states.
//  Accept: registered eng_valid=1, eng_din=s_data next cycle (latency 1); in_flight++,
//   sent_cnt++. On s_last: last_id<=sent_cnt (pre-increment value).
//  eng_done: push {eng_dout, recv_cnt==last_id & last_seen} into FIFO; in_flight--; recv_cnt++.
//   An accept and an eng_done in the same cycle leave in_flight unchanged.
//   A push and a pop in the same cycle on a full FIFO are legal.
//  m_valid/m_data/m_last come straight from the FIFO head (first-word-fall-through); pop on m_valid&m_ready.
//  Pipeline order is preserved, so no reordering. in_flight is CNT_W bits wide, and
//   credits are checked before accept.
//  Counters wrap modulo 2^CNT_W; only the equality with last_id is used.
//  Error: on eng_done with the FIFO full (no pop that cycle) the byte is dropped and err_ovf is set.
//   On eng_done with in_flight==0, err_ovf is set and no push occurs. err_ovf clears only on reset.
//  Zero-length message is not supported; a message ends only via s_last.
//  Reset mid-message: everything returns to IDLE immediately; bytes in flight are lost.
// STRUCTURE
//  Package enigma_pkg: state enum (IDLE, SET, SETTLE, RUN, DRAIN), BYTE_W=8 constant.
//  Sub-module: enigma_res_fifo (synchronous FWFT FIFO, width 9, depth FIFO_DEPTH,
//   full/empty/count outputs). The FSM, credit logic and counters live in this top.
// TESTING (bench uses a behavioural engine model with configurable fixed latency L and a byte mapping f)
//  T1 reset: assert reset mid-RUN -> all outputs 0 asynchronously, busy=0, FIFO empty.
//  T2 config: cfg_start, cfg_dec=1 -> eng_set high exactly 1 cycle, eng_dec=1,
//     s_ready first high SETTLE_CYC+1 cycles after eng_set.
//  T3 stream: 5 bytes 0x41..0x45 with last on 0x45, m_ready=1, L=7 -> m_data=f(0x41..0x45) in order;
//     m_last only on the 5th; msg_done pulse; busy=0.
//  T4 backpressure: m_ready=0, 20 bytes offered -> exactly FIFO_DEPTH accepted, err_ovf=0;
//     release m_ready -> all 20 delivered in order.
//  T5 simultaneous: accept + eng_done + pop in one cycle with FIFO full-1 -> counts stay consistent, no loss.
//  T6 error: inject eng_done with nothing in flight -> err_ovf=1 and sticky, FIFO unchanged.

Source files
------------

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared state encoding and byte width for the enigma stream controller
package enigma_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, SET, SETTLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/enigma_res_fifo.sv
// enigma_res_fifo: first-word-fall-through result FIFO with occupancy count
module enigma_res_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr_en, rd_en;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    rd_en = pop & ~empty;
    wr_en = push & (~full | rd_en);
    wr_d = wr_q + AW'(wr_en);
    rd_d = rd_q + AW'(rd_en);
    cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= din;
endmodule

// File: rtl/enigma_stream_ctrl.sv
// enigma_stream_ctrl: configures the enigma pipeline then streams bytes through it with credit-based result buffering
module enigma_stream_ctrl
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_dec,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              m_valid,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              eng_set,
  output logic              eng_en,
  output logic              eng_valid,
  output logic [BYTE_W-1:0] eng_din,
  output logic              eng_dec,
  input  logic              eng_done,
  input  logic [BYTE_W-1:0] eng_dout,
  output logic              busy,
  output logic              msg_done,
  output logic              err_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SETTLE_CYC) + 1;
  state_t state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] in_flight_q, in_flight_d, sent_q, sent_d, recv_q, recv_d, last_id_q, last_id_d;
  logic last_seen_q, last_seen_d, err_q, err_d, eng_valid_q, eng_valid_d, eng_dec_q, eng_dec_d;
  logic [BYTE_W-1:0] eng_din_q, eng_din_d;
  logic start, accept, pop, done_ok, push, fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic [BYTE_W:0] head;
  enigma_res_fifo #(.W(BYTE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .din({eng_dout, (recv_q == last_id_q) & last_seen_q}),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  assign s_ready = (state_q == RUN) &
                   ((CNT_W+1)'(in_flight_q) + (CNT_W+1)'(fifo_count) < (CNT_W+1)'(FIFO_DEPTH));
  assign m_valid = ~fifo_empty;
  assign m_data = fifo_empty ? '0 : head[BYTE_W:1];
  assign m_last = ~fifo_empty & head[0];
  assign eng_set = state_q == SET;
  assign eng_en = (state_q == RUN) | (state_q == DRAIN);
  assign eng_valid = eng_valid_q;
  assign eng_din = eng_din_q;
  assign eng_dec = eng_dec_q;
  assign busy = state_q != IDLE;
  assign msg_done = (state_q == DRAIN) & pop & m_last;
  assign err_ovf = err_q;
  always_comb begin
    start = (state_q == IDLE) & cfg_start;
    accept = s_valid & s_ready;
    pop = m_valid & m_ready;
    done_ok = eng_done & (in_flight_q != '0);
    push = done_ok & (~fifo_full | pop);
  end
  always_comb begin
    state_d = state_q;
    settle_d = settle_q;
    case (state_q)
      IDLE:   state_d = cfg_start ? SET : IDLE;
      SET: begin
        state_d = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        settle_d = settle_q + SW'(1);
        state_d = settle_q == SW'(SETTLE_CYC - 1) ? RUN : SETTLE;
      end
      RUN:    state_d = accept & s_last ? DRAIN : RUN;
      DRAIN:  state_d = msg_done ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    eng_valid_d = accept;
    eng_din_d = accept ? s_data : eng_din_q;
    eng_dec_d = start ? cfg_dec : eng_dec_q;
    in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(done_ok);
    sent_d = start ? '0 : sent_q + CNT_W'(accept);
    recv_d = start ? '0 : recv_q + CNT_W'(done_ok);
    last_id_d = accept & s_last ? sent_q : last_id_q;
    last_seen_d = start ? 1'b0 : last_seen_q | (accept & s_last);
    err_d = err_q | (eng_done & ~push);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      settle_q <= '0;
      in_flight_q <= '0;
      sent_q <= '0;
      recv_q <= '0;
      last_id_q <= '0;
      last_seen_q <= 1'b0;
      err_q <= 1'b0;
      eng_valid_q <= 1'b0;
      eng_din_q <= '0;
      eng_dec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      settle_q <= settle_d;
      in_flight_q <= in_flight_d;
      sent_q <= sent_d;
      recv_q <= recv_d;
      last_id_q <= last_id_d;
      last_seen_q <= last_seen_d;
      err_q <= err_d;
      eng_valid_q <= eng_valid_d;
      eng_din_q <= eng_din_d;
      eng_dec_q <= eng_dec_d;
    end
endmodule
